pb_debounce_arbiter: RTL and testbench
======================================

Name: pb_debounce_arbiter

Overview:
- Debounces N_PB raw push-buttons using one shared stability counter instead of one counter per button.
- A round-robin arbiter grants the counter to one button whose synchronized level differs from its debounced state.
- Once that button has been stable for DELAY cycles, its state toggles and a one-cycle pressed or released pulse is emitted.
- Sits between the board PB pins and the user FSMs; it replaces per-button debouncer instances when the button count is large.

Parameters:
- N_PB, 4: number of push-buttons, 1..16.
- DELAY, 500: consecutive stable cycles required to accept a change; must be at least 2.
- DELAY_WIDTH, $clog2(DELAY): shared counter width.
- ID_WIDTH, (N_PB>1 ? $clog2(N_PB) : 1): width of the grant index.

Ports:
- clk  input  1  base clock; all logic on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- PB  input  N_PB  raw asynchronous button inputs.
- PB_pressed_status  output  N_PB  debounced level per button.
- PB_pressed_pulse  output  N_PB  one-cycle pulse on accepted 0->1.
- PB_released_pulse  output  N_PB  one-cycle pulse on accepted 1->0.
- busy  output  1  high while the counter is granted (state COUNT).
- grant_id  output  ID_WIDTH  index of the granted button; valid when busy=1.

Behaviour:
- Reset (rst_n=0 at a posedge), all cleared: sync flops=0, PB_pressed_status=0, pulses=0, busy=0, grant_id=0, counter=0, rr pointer=0, state=IDLE. Reset wins over every other event, including mid-COUNT.
- Synchronizer: each PB bit passes through 2 flops to give PB_sync[i]. Then diff[i] = PB_sync[i] XOR PB_pressed_status[i].
- State IDLE:
  - No diff bit set: stay in IDLE.
  - Otherwise grant the first set diff bit searching upward from the pointer, wrapping past N_PB-1 to 0.
  - Load grant_id, clear the counter, go to COUNT.
- State COUNT:
  - diff[grant_id]=0 (bounce back): abort. Counter=0, pointer=grant_id+1 mod N_PB, go to IDLE. No pulse, no status change.
  - Else if counter==DELAY-1: commit. Toggle PB_pressed_status[grant_id]. Assert the matching pulse bit for exactly the next cycle: pressed if the new status is 1, released if 0. Pointer=grant_id+1 mod N_PB, counter=0, go to IDLE.
  - Else: counter+1.
- Latency: a clean edge held on an idle arbiter updates status and pulse on the (DELAY+3)-th posedge after the first edge that samples it. Breakdown: 2 sync edges, 1 grant edge, DELAY count/commit edges.
- Pulses are registered, so they coincide with the cycle the status changes. At most one pulse bit is set in any cycle.
- Non-granted buttons with diff=1 wait; their diff is re-evaluated at each grant. A button that reverts while waiting is never granted.
- Fairness: worst-case wait for a stable changed button is (N_PB-1)*(DELAY+1) cycles beyond its own latency.
- IDLE lasts 1 cycle between grants; back-to-back grants are allowed.
- Counter never wraps: it is bounded by DELAY-1.
- N_PB=1: pointer is constant 0; behaviour is a single debouncer.

Decomposition:
- Package pb_pkg: state enum typedef (IDLE, COUNT), plus a function rr_pick(req vector, pointer) that returns an index and a found flag.
- Sub-module pb_sync: parameterized N-bit 2-flop synchronizer with synchronous active-low reset. Instantiated once.
- The arbiter FSM, counter and status registers stay in pb_debounce_arbiter.

Test Plan (N_PB=4, DELAY=4):
1. Reset and quiet inputs: assert rst_n=0 for 3 cycles, then PB=0 for 20 cycles -> all outputs 0, busy=0 throughout.
2. Clean press: PB[2] 0->1, held -> PB_pressed_status[2]=1 and PB_pressed_pulse[2]=1 for one cycle on the 7th edge, grant_id=2 while busy. Then release PB[2] -> PB_released_pulse[2] after 7 edges.
3. Bounce: PB[1] high for 3 cycles, low 2, then held high -> first grant aborts with no pulse. Status rises 7 edges after the final stable edge.
4. Simultaneous: PB[0] and PB[3] rise in the same cycle, pointer=0 -> button 0 commits first. Button 3 is granted the cycle after return to IDLE and its pulse lands exactly 5 cycles after button 0's.
5. Round-robin: all four PB rise together after a commit on button 1 (pointer=2) -> commit order 2,3,0,1.
6. Reset mid-COUNT: pull rst_n low while counter=2 on PB[0] -> next cycle all status 0, busy=0. After release with PB[0] still high, a full DELAY+3 relatch follows.

Source files
------------

// File: rtl/pb_pkg.sv
// Shared types and helpers for the push-button debounce arbiter.
package pb_pkg;

  // Upper bounds on button count and grant index width.
  localparam int unsigned MAX_PB = 16;
  localparam int unsigned MAX_ID = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } pb_state_e;

  typedef struct packed {
    logic              found;
    logic [MAX_ID-1:0] idx;
  } rr_pick_t;

  // Return the first set request at or above ptr, wrapping at n-1 back to 0.
  function automatic rr_pick_t rr_pick(input logic [MAX_PB-1:0] req,
                                       input logic [MAX_ID-1:0] ptr,
                                       input int unsigned       n);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned k = 0; k < MAX_PB; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= n) begin
        cand = cand - n;
      end
      if ((k < n) && !res.found && req[cand[MAX_ID-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[MAX_ID-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pb_sync.sv
// N-bit two-flop synchronizer for asynchronous button inputs.
module pb_sync #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] meta_reg;
  logic [N-1:0] sync_reg;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      // Two back-to-back flops per bit to settle metastability.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          meta_reg[gi] <= 1'b0;
          sync_reg[gi] <= 1'b0;
        end else begin
          meta_reg[gi] <= d[gi];
          sync_reg[gi] <= meta_reg[gi];
        end
      end
    end
  endgenerate

  assign q = sync_reg;

endmodule

// File: rtl/pb_debounce_arbiter.sv
// Debounces N_PB buttons with one shared stability counter handed out round-robin.
module pb_debounce_arbiter
  import pb_pkg::*;
#(
  parameter int N_PB        = 4,
  parameter int DELAY       = 500,
  parameter int DELAY_WIDTH = $clog2(DELAY),
  parameter int ID_WIDTH    = (N_PB > 1) ? $clog2(N_PB) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_PB-1:0]     PB,
  output logic [N_PB-1:0]     PB_pressed_status,
  output logic [N_PB-1:0]     PB_pressed_pulse,
  output logic [N_PB-1:0]     PB_released_pulse,
  output logic                busy,
  output logic [ID_WIDTH-1:0] grant_id
);

  logic [N_PB-1:0]        pb_sync_lvl;
  logic [N_PB-1:0]        diff;
  pb_state_e              state_reg, state_next;
  logic [DELAY_WIDTH-1:0] count_reg, count_next;
  logic [ID_WIDTH-1:0]    grant_reg, grant_next;
  logic [ID_WIDTH-1:0]    ptr_reg, ptr_next;
  logic [ID_WIDTH-1:0]    grant_succ;
  logic [N_PB-1:0]        status_reg, status_next;
  logic [N_PB-1:0]        pressed_reg, pressed_next;
  logic [N_PB-1:0]        released_reg, released_next;
  logic [MAX_PB-1:0]      req_ext;
  rr_pick_t               pick;
  logic                   pick_unused;

  pb_sync #(.N(N_PB)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (PB),
    .q     (pb_sync_lvl)
  );

  // A button wants the counter while its settled level disagrees with its debounced state.
  assign diff = pb_sync_lvl ^ status_reg;

  // Widen the request vector to the helper's fixed size.
  always_comb begin
    req_ext            = '0;
    req_ext[N_PB-1:0]  = diff;
  end

  assign pick        = rr_pick(req_ext, MAX_ID'(ptr_reg), N_PB);
  assign pick_unused = ^pick.idx;

  // Next pointer position after the current grant finishes, wrapping at N_PB-1.
  assign grant_succ = (grant_reg == ID_WIDTH'(N_PB - 1)) ? '0 : grant_reg + ID_WIDTH'(1);

  // State, counter, status and pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      grant_reg    <= '0;
      ptr_reg      <= '0;
      status_reg   <= '0;
      pressed_reg  <= '0;
      released_reg <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      grant_reg    <= grant_next;
      ptr_reg      <= ptr_next;
      status_reg   <= status_next;
      pressed_reg  <= pressed_next;
      released_reg <= released_next;
    end
  end

  // Grant / count / commit / abort decisions.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    grant_next    = grant_reg;
    ptr_next      = ptr_reg;
    status_next   = status_reg;
    pressed_next  = '0;
    released_next = '0;
    case (state_reg)
      IDLE: begin
        if (pick.found) begin
          grant_next = pick.idx[ID_WIDTH-1:0];
          count_next = '0;
          state_next = COUNT;
        end
      end
      COUNT: begin
        if (!diff[grant_reg]) begin
          // Input bounced back before the counter filled: drop the grant silently.
          count_next = '0;
          ptr_next   = grant_succ;
          state_next = IDLE;
        end else if (count_reg == DELAY_WIDTH'(DELAY - 1)) begin
          status_next[grant_reg] = ~status_reg[grant_reg];
          if (status_reg[grant_reg]) begin
            released_next[grant_reg] = 1'b1;
          end else begin
            pressed_next[grant_reg] = 1'b1;
          end
          count_next = '0;
          ptr_next   = grant_succ;
          state_next = IDLE;
        end else begin
          count_next = count_reg + DELAY_WIDTH'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign PB_pressed_status = status_reg;
  assign PB_pressed_pulse  = pressed_reg;
  assign PB_released_pulse = released_reg;
  assign busy              = (state_reg == COUNT);
  assign grant_id          = grant_reg;

endmodule

// File: tb/tb_pb_debounce_arbiter.sv
// Directed bench for pb_debounce_arbiter with a cycle model and literal checkpoints.
module tb_pb_debounce_arbiter;

  localparam int NPB   = 4;
  localparam int DLY   = 4;
  localparam int IDW   = 2;

  logic           clk;
  logic           rst_n;
  logic [NPB-1:0] PB;
  logic [NPB-1:0] PB_pressed_status;
  logic [NPB-1:0] PB_pressed_pulse;
  logic [NPB-1:0] PB_released_pulse;
  logic           busy;
  logic [IDW-1:0] grant_id;

  int tests = 0;
  int fails = 0;

  pb_debounce_arbiter #(
    .N_PB  (NPB),
    .DELAY (DLY)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .PB                (PB),
    .PB_pressed_status (PB_pressed_status),
    .PB_pressed_pulse  (PB_pressed_pulse),
    .PB_released_pulse (PB_released_pulse),
    .busy              (busy),
    .grant_id          (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Inputs as seen at each rising edge.
  logic [NPB-1:0] pb_e;
  logic           rst_e;
  always @(posedge clk) begin
    pb_e  <= PB;
    rst_e <= rst_n;
  end

  // Model state: pipeline of the last two samples, debounced level, pulses,
  // granted button (-1 when nobody holds the counter), how many cycles it has held it,
  // and where the next search starts.
  logic [NPB-1:0] m_s1 = '0, m_s2 = '0, m_status = '0, m_pp = '0, m_pr = '0;
  int             m_gr = -1, m_held = 0, m_ptr = 0;

  task automatic chk_cyc(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Advance the model by one edge, then compare every observable output.
  always @(negedge clk) begin : cmp
    logic [NPB-1:0] want;
    want = m_s2 ^ m_status;
    if (!rst_e) begin
      m_s1 = '0; m_s2 = '0; m_status = '0; m_pp = '0; m_pr = '0;
      m_gr = -1; m_held = 0; m_ptr = 0;
    end else begin
      m_pp = '0;
      m_pr = '0;
      if (m_gr < 0) begin
        for (int k = 0; k < NPB; k++) begin
          if (m_gr < 0 && want[(m_ptr + k) % NPB]) begin
            m_gr   = (m_ptr + k) % NPB;
            m_held = 0;
          end
        end
      end else if (!want[m_gr]) begin
        m_ptr = (m_gr + 1) % NPB;
        m_gr  = -1;
      end else if (m_held + 1 == DLY) begin
        m_status[m_gr] = ~m_status[m_gr];
        if (m_status[m_gr]) m_pp[m_gr] = 1'b1;
        else                m_pr[m_gr] = 1'b1;
        m_ptr = (m_gr + 1) % NPB;
        m_gr  = -1;
      end else begin
        m_held++;
      end
      m_s2 = m_s1;
      m_s1 = pb_e;
    end
    chk_cyc("status",   32'(PB_pressed_status), 32'(m_status));
    chk_cyc("pressed",  32'(PB_pressed_pulse),  32'(m_pp));
    chk_cyc("released", 32'(PB_released_pulse), 32'(m_pr));
    chk_cyc("busy",     32'(busy),              32'(m_gr >= 0));
    if (m_gr >= 0) chk_cyc("grant_id", 32'(grant_id), 32'(m_gr));
    chk_cyc("one_pulse", 32'($countones(PB_pressed_pulse | PB_released_pulse) <= 1), 32'd1);
  end

  // ---------------- directed stimulus ----------------
  task automatic expect_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end else begin
      $display("[TB] %s ok: %0h", name, act);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    PB    = '0;

    // 1. reset and quiet inputs
    wait_cyc(3);
    expect_lit("t1_reset_outputs",
               {20'd0, PB_pressed_status, PB_pressed_pulse, PB_released_pulse}, 32'd0);
    expect_lit("t1_reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wait_cyc(20);
    expect_lit("t1_quiet_status", 32'(PB_pressed_status), 32'd0);
    expect_lit("t1_quiet_busy", 32'(busy), 32'd0);

    // 2. clean press and release on button 2
    PB = 4'b0100;
    wait_cyc(6);
    expect_lit("t2_busy_before_commit", 32'(busy), 32'd1);
    expect_lit("t2_grant", 32'(grant_id), 32'd2);
    expect_lit("t2_status_before", 32'(PB_pressed_status), 32'd0);
    wait_cyc(1);
    expect_lit("t2_status_edge7", 32'(PB_pressed_status), 32'b0100);
    expect_lit("t2_pressed_edge7", 32'(PB_pressed_pulse), 32'b0100);
    wait_cyc(1);
    expect_lit("t2_pulse_one_cycle", 32'(PB_pressed_pulse), 32'd0);
    PB = 4'b0000;
    wait_cyc(6);
    expect_lit("t2_released_before", 32'(PB_released_pulse), 32'd0);
    wait_cyc(1);
    expect_lit("t2_released_edge7", 32'(PB_released_pulse), 32'b0100);
    expect_lit("t2_status_cleared", 32'(PB_pressed_status), 32'd0);

    // 3. bounce on button 1
    PB = 4'b0010;
    wait_cyc(3);
    expect_lit("t3_first_grant", {30'd0, busy, 1'b0} | 32'(grant_id), 32'd3);
    PB = 4'b0000;
    wait_cyc(2);
    PB = 4'b0010;
    wait_cyc(1);
    expect_lit("t3_aborted_busy", 32'(busy), 32'd0);
    expect_lit("t3_aborted_status", 32'(PB_pressed_status), 32'd0);
    wait_cyc(5);
    expect_lit("t3_status_before", 32'(PB_pressed_status), 32'd0);
    wait_cyc(1);
    expect_lit("t3_status_edge7", 32'(PB_pressed_status), 32'b0010);
    expect_lit("t3_pressed_edge7", 32'(PB_pressed_pulse), 32'b0010);

    // clear back to a known pointer of 0
    PB    = '0;
    rst_n = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(3);
    expect_lit("t4_cleared", 32'(PB_pressed_status), 32'd0);

    // 4. simultaneous press on buttons 0 and 3
    PB = 4'b1001;
    wait_cyc(7);
    expect_lit("t4_first_commit", 32'(PB_pressed_pulse), 32'b0001);
    wait_cyc(4);
    expect_lit("t4_second_grant", {30'd0, busy, 1'b0} | 32'(grant_id), 32'd3);
    expect_lit("t4_no_pulse_between", 32'(PB_pressed_pulse), 32'd0);
    wait_cyc(1);
    expect_lit("t4_second_commit", 32'(PB_pressed_pulse), 32'b1000);
    expect_lit("t4_status", 32'(PB_pressed_status), 32'b1001);

    // 5. round-robin after a commit on button 1
    PB = 4'b0000;
    wait_cyc(12);
    expect_lit("t5_release_3", 32'(PB_released_pulse), 32'b1000);
    expect_lit("t5_all_low", 32'(PB_pressed_status), 32'd0);
    PB = 4'b0010;
    wait_cyc(7);
    expect_lit("t5_press_1", 32'(PB_pressed_pulse), 32'b0010);
    PB = 4'b0000;
    wait_cyc(7);
    expect_lit("t5_release_1", 32'(PB_released_pulse), 32'b0010);
    PB = 4'b1111;
    wait_cyc(7);
    expect_lit("t5_order_2", 32'(PB_pressed_pulse), 32'b0100);
    wait_cyc(5);
    expect_lit("t5_order_3", 32'(PB_pressed_pulse), 32'b1000);
    wait_cyc(5);
    expect_lit("t5_order_0", 32'(PB_pressed_pulse), 32'b0001);
    wait_cyc(5);
    expect_lit("t5_order_1", 32'(PB_pressed_pulse), 32'b0010);
    expect_lit("t5_status_all", 32'(PB_pressed_status), 32'b1111);

    // 6. reset in the middle of a count
    PB = 4'b0000;
    wait_cyc(25);
    expect_lit("t6_all_released", 32'(PB_pressed_status), 32'd0);
    PB = 4'b0001;
    wait_cyc(5);
    expect_lit("t6_counting", {30'd0, busy, 1'b0} | 32'(grant_id), 32'd2);
    rst_n = 1'b0;
    wait_cyc(1);
    expect_lit("t6_reset_busy", 32'(busy), 32'd0);
    expect_lit("t6_reset_status", 32'(PB_pressed_status), 32'd0);
    rst_n = 1'b1;
    wait_cyc(6);
    expect_lit("t6_relatch_before", 32'(PB_pressed_status), 32'd0);
    wait_cyc(1);
    expect_lit("t6_relatch_status", 32'(PB_pressed_status), 32'b0001);
    expect_lit("t6_relatch_pulse", 32'(PB_pressed_pulse), 32'b0001);

    wait_cyc(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
